fifo_async_top: RTL and testbench



---
 rtl/fifo_async_top.sv | 108 ++++++++++
 tb/tb_fifo_async_top.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_async_top.sv
// Dual-clock FIFO. Gray-coded pointers cross the clock domains through
// two-flop synchronizers. The full and empty flags are registered in
// their own domains, and read data is registered.
module fifo_async_top #(
    parameter int MEMORY_WIDTH = 4,
    parameter int MEMORY_DEPTH = 4,
    parameter int ADDRESS_SIZE = 2
) (
    input  logic                    w_clk,
    input  logic                    wrst_n,
    input  logic                    r_clk,
    input  logic                    rrst_n,
    input  logic                    w_en,
    input  logic [MEMORY_WIDTH-1:0] wdata,
    input  logic                    r_en,
    output logic [MEMORY_WIDTH-1:0] rdata,
    output logic                    w_full,
    output logic                    r_empty
);
    localparam int PW = ADDRESS_SIZE + 1;
    // Full means the write pointer has lapped the read pointer by exactly one
    // trip round the array. In Gray code that is the read pointer with its
    // two MSBs inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    logic [MEMORY_WIDTH-1:0] mem [MEMORY_DEPTH];

    // ---------------- write domain ----------------
    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wq1_rptr_q, wq2_rptr_q;
    logic          w_full_q, w_full_d;
    logic          w_push;

    assign w_push = w_en && !w_full_q;

    // Next write pointer (binary and Gray) and look-ahead full flag
    always_comb begin
        wbin_d   = wbin_q + PW'(w_push);
        wptr_d   = wbin_d ^ (wbin_d >> 1);
        w_full_d = (wptr_d == (wq2_rptr_q ^ FULL_MASK));
    end

    // Write pointer, full flag and read-pointer synchronizer state
    always_ff @(posedge w_clk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q     <= '0;
            wptr_q     <= '0;
            wq1_rptr_q <= '0;
            wq2_rptr_q <= '0;
            w_full_q   <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wptr_q     <= wptr_d;
            wq1_rptr_q <= rptr_q;
            wq2_rptr_q <= wq1_rptr_q;
            w_full_q   <= w_full_d;
        end
    end

    // Storage array has no reset; writes happen only when space is known
    always_ff @(posedge w_clk) begin
        if (w_push)
            mem[wbin_q[ADDRESS_SIZE-1:0]] <= wdata;
    end

    // ---------------- read domain ----------------
    logic [PW-1:0]           rbin_q, rbin_d;
    logic [PW-1:0]           rptr_q, rptr_d;
    logic [PW-1:0]           rq1_wptr_q, rq2_wptr_q;
    logic                    r_empty_q, r_empty_d;
    logic [MEMORY_WIDTH-1:0] rdata_q;
    logic                    r_pop;

    assign r_pop = r_en && !r_empty_q;

    // Next read pointer (binary and Gray) and look-ahead empty flag
    always_comb begin
        rbin_d    = rbin_q + PW'(r_pop);
        rptr_d    = rbin_d ^ (rbin_d >> 1);
        r_empty_d = (rptr_d == rq2_wptr_q);
    end

    // Read pointer, empty flag, read data and write-pointer synchronizer state
    always_ff @(posedge r_clk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_q     <= '0;
            rptr_q     <= '0;
            rq1_wptr_q <= '0;
            rq2_wptr_q <= '0;
            r_empty_q  <= 1'b1;
            rdata_q    <= '0;
        end else begin
            rbin_q     <= rbin_d;
            rptr_q     <= rptr_d;
            rq1_wptr_q <= wptr_q;
            rq2_wptr_q <= rq1_wptr_q;
            r_empty_q  <= r_empty_d;
            if (r_pop)
                rdata_q <= mem[rbin_q[ADDRESS_SIZE-1:0]];
        end
    end

    assign rdata   = rdata_q;
    assign w_full  = w_full_q;
    assign r_empty = r_empty_q;

endmodule

// File: tb/tb_fifo_async_top.sv
// Directed bench for fifo_async_top: w_clk 10 ns, r_clk 20 ns.
module tb_fifo_async_top;
    logic       w_clk = 1'b0;
    logic       r_clk = 1'b0;
    logic       wrst_n = 1'b0;
    logic       rrst_n = 1'b0;
    logic       w_en = 1'b0;
    logic [3:0] wdata = '0;
    logic       r_en = 1'b0;
    logic [3:0] rdata;
    logic       w_full;
    logic       r_empty;

    int vectors = 0;
    int miscompares = 0;

    fifo_async_top #(.MEMORY_WIDTH(4), .MEMORY_DEPTH(4), .ADDRESS_SIZE(2)) dut (
        .w_clk  (w_clk),
        .wrst_n (wrst_n),
        .r_clk  (r_clk),
        .rrst_n (rrst_n),
        .w_en   (w_en),
        .wdata  (wdata),
        .r_en   (r_en),
        .rdata  (rdata),
        .w_full (w_full),
        .r_empty(r_empty)
    );

    always #5  w_clk = ~w_clk;
    always #10 r_clk = ~r_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(posedge w_clk);
        #1;
    endtask

    task automatic rcyc(input int n);
        repeat (n) @(posedge r_clk);
        #1;
    endtask

    // Single write: w_en high for exactly one w_clk edge
    task automatic wr1(input logic [3:0] d);
        @(posedge w_clk); #1;
        w_en = 1'b1; wdata = d;
        @(posedge w_clk); #1;
        w_en = 1'b0;
    endtask

    // Bounded wait for r_empty to drop
    task automatic wait_not_empty(input string tag);
        for (int k = 0; k < 10; k++) begin
            if (!r_empty) break;
            rcyc(1);
        end
        chk(tag, 32'(r_empty), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v;
        int got;
        // ---- reset ----
        #13;
        chk("rst_empty", 32'(r_empty), 32'd1);
        chk("rst_full",  32'(w_full),  32'd0);
        chk("rst_rdata", 32'(rdata),   32'd0);
        wrst_n = 1'b1; rrst_n = 1'b1;
        wcyc(2);
        chk("rst_idle_empty", 32'(r_empty), 32'd1);

        // ---- single word ----
        wr1(4'h1);
        rcyc(3);
        chk("single_empty_fall", 32'(r_empty), 32'd0);
        @(posedge r_clk); #1; r_en = 1'b1;
        rcyc(1); r_en = 1'b0;
        chk("single_rdata", 32'(rdata),   32'h1);
        chk("single_empty", 32'(r_empty), 32'd1);
        wcyc(6);

        // ---- overfill: 1..5 with w_en held ----
        @(posedge w_clk); #1;
        w_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wdata = 4'(i);
            @(posedge w_clk); #1;
            if (i == 3) chk("ovf_full_after3", 32'(w_full), 32'd0);
            if (i == 4) chk("ovf_full_after4", 32'(w_full), 32'd1);
        end
        w_en = 1'b0;
        chk("ovf_full_hold", 32'(w_full), 32'd1);
        wait_not_empty("ovf_empty_fall");
        @(posedge r_clk); #1; r_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            rcyc(1);
            chk("ovf_drain_data", 32'(rdata), 32'(i));
            if (i < 4) chk("ovf_drain_notempty", 32'(r_empty), 32'd0);
        end
        r_en = 1'b0;
        chk("ovf_drain_empty", 32'(r_empty), 32'd1);
        wcyc(4);
        chk("ovf_full_fall", 32'(w_full), 32'd0);

        // ---- read on empty: r_en high 100 ns ----
        @(posedge r_clk); #1; r_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            rcyc(1);
            chk("rdempty_rdata", 32'(rdata),   32'h4);
            chk("rdempty_empty", 32'(r_empty), 32'd1);
        end
        r_en = 1'b0;
        // A fresh word must come back; a moved rbin would return stale data
        wr1(4'hA);
        wait_not_empty("rdempty_wr_empty_fall");
        @(posedge r_clk); #1; r_en = 1'b1;
        rcyc(1); r_en = 1'b0;
        chk("rdempty_next_word", 32'(rdata), 32'hA);
        chk("rdempty_next_empty", 32'(r_empty), 32'd1);
        wcyc(6);

        // ---- wrap: 10 rounds of 3 words ----
        for (int rnd = 0; rnd < 10; rnd++) begin
            @(posedge w_clk); #1;
            w_en = 1'b1;
            for (int k = 0; k < 3; k++) begin
                wdata = 4'(rnd * 3 + k + 1);
                @(posedge w_clk); #1;
                chk("wrap_no_full", 32'(w_full), 32'd0);
            end
            w_en = 1'b0;
            wait_not_empty("wrap_empty_fall");
            @(posedge r_clk); #1; r_en = 1'b1;
            for (int k = 0; k < 3; k++) begin
                rcyc(1);
                v = 4'(rnd * 3 + k + 1);
                chk("wrap_data", 32'(rdata), 32'(v));
                chk("wrap_empty", 32'(r_empty), (k == 2) ? 32'd1 : 32'd0);
            end
            r_en = 1'b0;
            wcyc(5);
        end

        // ---- concurrency: stream 1..16, reader always requesting ----
        got = 0;
        fork
            begin : writer
                int idx;
                logic f;
                idx = 1;
                @(posedge w_clk); #1;
                for (int t = 0; t < 400 && idx <= 16; t++) begin
                    wdata = 4'(idx);
                    w_en  = 1'b1;
                    f     = w_full;
                    @(posedge w_clk); #1;
                    if (!f) idx++;
                end
                w_en = 1'b0;
                chk("conc_all_written", 32'(idx), 32'd17);
            end
            begin : reader
                logic e;
                logic [3:0] ev;
                @(posedge r_clk); #1;
                r_en = 1'b1;
                for (int t = 0; t < 400 && got < 16; t++) begin
                    e = r_empty;
                    rcyc(1);
                    if (!e) begin
                        got++;
                        ev = 4'(got);
                        chk("conc_data", 32'(rdata), 32'(ev));
                    end
                end
                r_en = 1'b0;
            end
        join
        chk("conc_count", 32'(got), 32'd16);
        rcyc(4);
        chk("conc_final_empty", 32'(r_empty), 32'd1);
        chk("conc_final_full",  32'(w_full),  32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
